// File: rtl/lsu_mem_access.sv
// Load/store unit: turns a decoded MemWr/MemOP access into one or two word-bus beats and a response.
// Latency: aligned access = accept + 3 cycles with a zero-wait bus; split adds 2; invalid op responds 1 cycle after accept.
// Backpressure: req_ready only in IDLE; bus_valid holds its beat stable until bus_ready; one beat outstanding.
module lsu_mem_access #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [2:0]       req_memop,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             bus_we,
  output logic [WIDTH-1:0] bus_addr,
  output logic [3:0]       bus_wstrb,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_rvalid,
  input  logic [WIDTH-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [2:0]       memop_q, memop_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;

  logic [1:0]         off;
  logic [3:0]         sz;
  logic [3:0]         mask;
  logic               split;
  logic [7:0]         m8;
  logic [2*WIDTH-1:0] d64;
  logic [2*WIDTH-1:0] r64;
  logic [WIDTH-1:0]   beat0_addr;
  logic [WIDTH-1:0]   beat1_addr;
  logic [WIDTH-1:0]   load_ext;
  logic               memop_ok;

  // Only lb/lh/lw/lbu/lhu encodings are legal; checked on the live request at accept.
  assign memop_ok = (req_memop[1:0] != 2'b11) && !(req_memop[2] && req_memop[1]);

  // Size, lane placement and beat addresses of the captured access.
  always_comb begin
    off = addr_q[1:0];
    sz   = 4'd4;
    mask = 4'b1111;
    case (memop_q[1:0])
      2'b00:   begin sz = 4'd1; mask = 4'b0001; end
      2'b01:   begin sz = 4'd2; mask = 4'b0011; end
      default: begin sz = 4'd4; mask = 4'b1111; end
    endcase
    split      = ({2'b00, off} + sz) > 4'd4;
    m8         = {4'b0000, mask} << off;
    d64        = {{WIDTH{1'b0}}, wdata_q} << {off, 3'b000};
    r64        = {rdata1_q, rdata0_q} >> {off, 3'b000};
    beat0_addr = {addr_q[WIDTH-1:2], 2'b00};
    beat1_addr = beat0_addr + 32'd4;
  end

  // Pick the low sz bytes of the realigned read data; memop[2] selects zero-extension.
  always_comb begin
    case (memop_q[1:0])
      2'b00:   load_ext = {{24{~memop_q[2] & r64[7]}},  r64[7:0]};
      2'b01:   load_ext = {{16{~memop_q[2] & r64[15]}}, r64[15:0]};
      default: load_ext = r64[31:0];
    endcase
  end

  // State register and captured access; reset abandons any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      memop_q  <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      memop_q  <= memop_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next state, data latching and all outputs; bus fields depend only on state and captured regs, so they stay stable while stalled.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    memop_d    = memop_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    bus_valid  = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wstrb  = 4'b0000;
    bus_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d     = req_wr;
          memop_d  = req_memop;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata0_d = '0;
          rdata1_d = '0;
          state_d  = memop_ok ? S_REQ0 : S_ERR;
        end
      end
      S_REQ0: begin
        bus_valid = 1'b1;
        bus_we    = wr_q;
        bus_addr  = beat0_addr;
        bus_wstrb = wr_q ? m8[3:0] : 4'b0000;
        bus_wdata = wr_q ? d64[WIDTH-1:0] : '0;
        if (bus_ready) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (bus_rvalid) begin
          rdata0_d = bus_rdata;
          state_d  = split ? S_REQ1 : S_DONE;
        end
      end
      S_REQ1: begin
        bus_valid = 1'b1;
        bus_we    = wr_q;
        bus_addr  = beat1_addr;
        bus_wstrb = wr_q ? m8[7:4] : 4'b0000;
        bus_wdata = wr_q ? d64[2*WIDTH-1:WIDTH] : '0;
        if (bus_ready) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (bus_rvalid) begin
          rdata1_d = bus_rdata;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = wr_q ? '0 : load_ext;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
